// File: rtl/card_shoe_if.sv
// Request/response bundle between the blackjack engine (master) and the card shoe (slave).
interface card_shoe_if;
  logic       shuffle_start;
  logic       deal_req;
  logic [3:0] card_rank;
  logic [4:0] card_out;
  logic       card_valid;
  logic       ready;
  logic       busy;
  logic       empty;
  logic [5:0] cards_left;
  logic       low_shoe;

  modport master (
    output shuffle_start, deal_req,
    input  card_rank, card_out, card_valid, ready, busy, empty, cards_left, low_shoe
  );

  modport slave (
    input  shuffle_start, deal_req,
    output card_rank, card_out, card_valid, ready, busy, empty, cards_left, low_shoe
  );
endinterface

// File: rtl/card_shoe.sv
// Single-deck shoe: LFSR-driven Fisher-Yates shuffle in place, then deals one rank per request
// without replacement, presenting both the raw rank and its blackjack value.
module card_shoe #(
  parameter int LOW_THRESH = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  card_shoe_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, SHUF_PICK, SHUF_SWAP, READY, EMPTY} state_t;

  state_t      state_reg;
  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;
  logic [5:0]  i_reg;
  logic [5:0]  j_reg;
  logic [5:0]  ptr_reg;
  logic [5:0]  cards_left_reg;
  logic [3:0]  card_rank_reg;
  logic [4:0]  card_out_reg;
  logic        card_valid_reg;
  logic        ready_reg;
  logic        busy_reg;
  logic        empty_reg;

  logic [3:0]  deck_reg  [52];
  logic [3:0]  deck_next [52];
  logic [3:0]  deck_i;
  logic [3:0]  deck_j;
  logic [3:0]  deck_top;
  logic [5:0]  mask;
  logic [5:0]  pick;
  logic        fill;
  logic        swap;

  assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

  // Smallest all-ones mask covering i keeps the rejection rate below one half.
  always_comb begin
    mask = 6'h01;
    if (i_reg >= 6'd32)      mask = 6'h3F;
    else if (i_reg >= 6'd16) mask = 6'h1F;
    else if (i_reg >= 6'd8)  mask = 6'h0F;
    else if (i_reg >= 6'd4)  mask = 6'h07;
    else if (i_reg >= 6'd2)  mask = 6'h03;
  end

  assign pick     = lfsr_reg[5:0] & mask;
  assign deck_i   = deck_reg[i_reg];
  assign deck_j   = deck_reg[j_reg];
  assign deck_top = deck_reg[ptr_reg];
  assign swap     = (state_reg == SHUF_SWAP);
  assign fill     = bus.shuffle_start &&
                    (state_reg == IDLE || state_reg == EMPTY || state_reg == READY);

  for (genvar gi = 0; gi < 52; gi++) begin : g_deck
    assign deck_next[gi] = fill                            ? 4'(gi / 4 + 1) :
                           (swap && i_reg == 6'(gi))       ? deck_j :
                           (swap && j_reg == 6'(gi))       ? deck_i :
                                                             deck_reg[gi];
  end

  always_ff @(posedge clk) begin
    deck_reg <= deck_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      lfsr_reg       <= (seed == 16'h0000) ? 16'h0001 : seed;
      i_reg          <= '0;
      j_reg          <= '0;
      ptr_reg        <= '0;
      cards_left_reg <= '0;
      card_rank_reg  <= '0;
      card_out_reg   <= '0;
      card_valid_reg <= 1'b0;
      ready_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      empty_reg      <= 1'b0;
    end else begin
      card_valid_reg <= 1'b0;
      case (state_reg)
        IDLE, EMPTY: begin
          if (bus.shuffle_start) begin
            state_reg <= SHUF_PICK;
            i_reg     <= 6'd51;
            busy_reg  <= 1'b1;
            ready_reg <= 1'b0;
            empty_reg <= 1'b0;
          end
        end
        SHUF_PICK: begin
          lfsr_reg <= lfsr_next;
          if (pick <= i_reg) begin
            j_reg     <= pick;
            state_reg <= SHUF_SWAP;
          end
        end
        SHUF_SWAP: begin
          i_reg <= i_reg - 6'd1;
          if (i_reg == 6'd1) begin
            state_reg      <= READY;
            ptr_reg        <= '0;
            cards_left_reg <= 6'd52;
            busy_reg       <= 1'b0;
            ready_reg      <= 1'b1;
          end else begin
            state_reg <= SHUF_PICK;
          end
        end
        READY: begin
          if (bus.shuffle_start) begin
            state_reg <= SHUF_PICK;
            i_reg     <= 6'd51;
            busy_reg  <= 1'b1;
            ready_reg <= 1'b0;
          end else if (bus.deal_req) begin
            card_rank_reg  <= deck_top;
            card_out_reg   <= (deck_top > 4'd10) ? 5'd10 : {1'b0, deck_top};
            card_valid_reg <= 1'b1;
            ptr_reg        <= ptr_reg + 6'd1;
            cards_left_reg <= cards_left_reg - 6'd1;
            if (cards_left_reg == 6'd1) begin
              state_reg <= EMPTY;
              ready_reg <= 1'b0;
              empty_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.card_rank  = card_rank_reg;
  assign bus.card_out   = card_out_reg;
  assign bus.card_valid = card_valid_reg;
  assign bus.ready      = ready_reg;
  assign bus.busy       = busy_reg;
  assign bus.empty      = empty_reg;
  assign bus.cards_left = cards_left_reg;
  assign bus.low_shoe   = (32'(cards_left_reg) < LOW_THRESH);
endmodule

// File: doc/card_shoe.md
# card_shoe

Single-deck card shoe that feeds the blackjack game engine's card path. It holds the 52 ranks, shuffles them in place with a deterministic LFSR-driven Fisher-Yates pass, and then deals one card per request without replacement. Each dealt card is presented both as a raw rank and as a blackjack value (Ace = 1, face = 10), so the game engine can take it on its `card_in`/`submit` path.

## Interface
- `LOW_THRESH`, default 15: `low_shoe` asserts when `cards_left < LOW_THRESH`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `seed` in 16: LFSR seed, sampled only while `reset` is high; value 0 is replaced by 16'h0001.
- `shuffle_start` in 1: level, sampled per cycle; starts a fresh shuffle.
- `deal_req` in 1: level, sampled per cycle; requests the next card.
- `card_rank` out 4: raw rank of the last dealt card, 1–13; holds between deals.
- `card_out` out 5: value of the last dealt card; rank 1 → 1, 2–10 → rank, 11–13 → 10.
- `card_valid` out 1: one-cycle pulse per dealt card.
- `ready` out 1: shuffled and at least one card left.
- `busy` out 1: shuffle in progress.
- `empty` out 1: all 52 cards dealt.
- `cards_left` out 6: cards remaining, 0–52.
- `low_shoe` out 1: combinational `cards_left < LOW_THRESH`; it is 1 at reset.

## Operation
- **Storage:** `deck[0..51]`, 4 bits each.
- **LFSR (16-bit Fibonacci):**
  - Feedback `l[15]^l[13]^l[12]^l[10]`, shift `{l[14:0], fb}`.
  - Advances only in SHUF_PICK.
  - Persists across shuffles; it is reloaded only by reset.
- **Reset values:** state IDLE, `lfsr` = seed (or 1), `ptr` = 0, `cards_left` = 0. All outputs are 0 except `low_shoe` = 1. Deck contents are don't-care.
- **IDLE:**
  - `shuffle_start` → SHUF_PICK.
  - On the same edge: `deck[k] = k/4 + 1` for every k (ranks 1,1,1,1,2,…,13,13,13,13), and `i` = 51.
  - `deal_req` is ignored.
- **SHUF_PICK:**
  - `mask` = all-ones of width bitlen(i), e.g. i = 51 → 6'h3F, i = 3 → 2'h3, i = 1 → 1'h1.
  - `r = lfsr[5:0] & mask`.
  - If `r <= i`: `j <= r`, go to SHUF_SWAP.
  - Otherwise stay (rejection).
  - LFSR advances every cycle in this state, on both accept and reject.
- **SHUF_SWAP:**
  - Exchange `deck[i]` and `deck[j]` (no-op when i == j), then `i <= i - 1`.
  - If the old i was 1: go to READY, `ptr` = 0, `cards_left` = 52.
  - Otherwise go back to SHUF_PICK.
- **READY:**
  - `deal_req` → `card_rank <= deck[ptr]`, `card_out` = mapped value, `card_valid` = 1 for one cycle, `ptr++`, `cards_left--`.
  - If `cards_left` goes 1 → 0: go to EMPTY.
  - `deal_req` held high deals one card per cycle.
- **EMPTY:** `deal_req` is ignored; `shuffle_start` → SHUF_PICK with a fresh deck fill, as from IDLE.
- **Simultaneous events:**
  - `shuffle_start` and `deal_req` together in READY: shuffle wins, no card is dealt, a fresh fill occurs.
  - `shuffle_start` while `busy`: ignored.
  - `deal_req` while `busy`: ignored; no `card_valid`.
- **Reset mid-operation:** `reset` at any time returns the block to the reset values immediately. A partially shuffled deck is never dealt.
- **Invariant:** the deck is always a permutation holding each rank exactly 4 times.

## Timing
- **Shuffle start:** `shuffle_start` sampled at edge N → `busy` = 1 and `ready` = 0 after edge N.
- **Shuffle length:** 51 swaps, each at least 2 cycles (PICK + SWAP), plus reject cycles. The minimum is 102 cycles from start to `ready`.
- **Shuffle end:** `busy` falls and `ready` rises on the same edge.
- **Deal latency:** `deal_req` high at edge N → `card_valid`, `card_rank`, `card_out` and `cards_left` updated after edge N (1-cycle latency).
- **Last card:** on the 52nd deal, `card_valid` = 1, `ready` = 0 and `empty` = 1 on the same cycle.
- **Status outputs:** `busy`, `ready` and `empty` are registered, decoded from state, and mutually exclusive (all 0 in IDLE).

## Test plan
- **Reset:** assert `reset` with `seed` = 0, release. Require all outputs 0 except `low_shoe` = 1, and internal `lfsr` = 16'h0001; `deal_req` for 5 cycles gives no `card_valid`.
- **Shuffle and full deal:** `seed` = 16'hACE1, `shuffle_start` for 1 cycle. Require `busy` for ≥102 cycles, then `ready` = 1 and `cards_left` = 52. Then hold `deal_req` for 52 cycles. Require:
  - 52 consecutive `card_valid` pulses;
  - each rank 1–13 seen exactly 4 times;
  - `card_out` = 10 for every rank 11–13;
  - `empty` = 1 after the last card.
- **Low shoe:** after 37 deals require `cards_left` = 15 and `low_shoe` = 0. On the 38th deal require `cards_left` = 14 and `low_shoe` = 1.
- **Ignored requests:** in EMPTY, pulse `deal_req`; require no `card_valid` and `cards_left` = 0. Then `shuffle_start`; require `ready` again with 52 cards and a different order (LFSR has advanced).
- **Shuffle priority:** in READY with 40 cards left, drive `shuffle_start` and `deal_req` together. Require no `card_valid` that cycle, `busy` = 1, and `cards_left` = 52 at the next `ready`.
- **Reset mid-shuffle:** assert `reset` 30 cycles into a shuffle. Require IDLE, `cards_left` = 0, `busy` = 0. Re-run with the same seed; require a card sequence identical to the first run from that seed.
